// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter for the RTC chip's multiplexed address/data bus.
// Each grant runs one full address phase + data phase with registered pin outputs.
module rtc_bus_arbiter #(
  parameter int unsigned T_PULSE = 5,
  parameter int unsigned T_GAP   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_write,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  req_done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        cs_n,
  output logic        ad_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in
);

  typedef enum logic [3:0] {
    IDLE, A_ADR, A_CS, A_WR, A_END, GAP, D_CS, D_STB, D_END, DONE
  } state_t;

  state_t      state, nxt;
  logic [1:0]  ptr, idx, gidx, cand;
  logic [2:0]  sum;
  logic        gfound, gwrite, write_q;
  logic [7:0]  gaddr, gwdata, addr_q, wdata_q, cnt;

  // First requester at or after the pointer, wrapping 2 -> 0.
  always_comb begin
    gfound = 1'b0;
    gidx   = '0;
    sum    = '0;
    cand   = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      cand = sum[1:0];
      if (!gfound && req_valid[cand]) begin
        gfound = 1'b1;
        gidx   = cand;
      end
    end
  end

  always_comb begin
    gaddr  = req_addr[23:16];
    gwdata = req_wdata[23:16];
    gwrite = req_write[2];
    case (gidx)
      2'd0: begin gaddr = req_addr[7:0];  gwdata = req_wdata[7:0];  gwrite = req_write[0]; end
      2'd1: begin gaddr = req_addr[15:8]; gwdata = req_wdata[15:8]; gwrite = req_write[1]; end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (gfound) nxt = A_ADR;
      A_ADR:   nxt = A_CS;
      A_CS:    nxt = A_WR;
      A_WR:    if (cnt == '0) nxt = A_END;
      A_END:   nxt = GAP;
      GAP:     if (cnt == '0) nxt = D_CS;
      D_CS:    nxt = D_STB;
      D_STB:   if (cnt == '0) nxt = D_END;
      D_END:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Pins are decoded from the next state so they are registered yet line up with it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      req_done <= '0;
      cs_n     <= 1'b1;
      ad_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '1;
    end else begin
      state <= nxt;
      busy  <= (nxt != IDLE);

      if (state == IDLE && gfound) begin
        idx     <= gidx;
        addr_q  <= gaddr;
        wdata_q <= gwdata;
        write_q <= gwrite;
      end

      if (nxt != state && (nxt == A_WR || nxt == D_STB))
        cnt <= 8'(T_PULSE - 1);
      else if (nxt != state && nxt == GAP)
        cnt <= 8'(T_GAP - 1);
      else if (cnt != '0)
        cnt <= cnt - 8'd1;

      if (state == D_STB && cnt == '0 && !write_q)
        rdata <= ad_in;

      if (state == DONE)
        ptr <= (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);

      cs_n     <= 1'b1;
      ad_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '1;
      req_done <= '0;
      case (nxt)
        A_ADR: begin
          ad_n   <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= gaddr;
        end
        A_CS, A_WR: begin
          ad_n   <= 1'b0;
          cs_n   <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= addr_q;
          if (nxt == A_WR) wr_n <= 1'b0;
        end
        A_END: begin
          ad_oe  <= 1'b1;
          ad_out <= addr_q;
        end
        GAP, D_CS, D_STB: begin
          if (write_q) begin
            ad_oe  <= 1'b1;
            ad_out <= wdata_q;
          end
          if (nxt != GAP) cs_n <= 1'b0;
          if (nxt == D_STB) begin
            if (write_q) wr_n <= 1'b0;
            else         rd_n <= 1'b0;
          end
        end
        DONE:    req_done <= 3'b001 << idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: per-cycle pin tables for whole accesses,
// plus hand-written withdraw, reset-in-GAP and three-way contention sequences.
module tb_rtc_bus_arbiter;

  localparam int unsigned TP = 5;
  localparam int unsigned TG = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_write, req_done;
  logic [23:0] req_addr, req_wdata;
  logic [7:0]  rdata, ad_out, ad_in;
  logic        busy, cs_n, ad_n, rd_n, wr_n, ad_oe;

  logic [2:0]  b_req_valid, b_req_write, b_req_done;
  logic [23:0] b_req_addr, b_req_wdata;
  logic [7:0]  b_rdata, b_ad_out, b_ad_in;
  logic        b_busy, b_cs_n, b_ad_n, b_rd_n, b_wr_n, b_ad_oe;

  always #5 clock = ~clock;

  rtc_bus_arbiter #(.T_PULSE(TP), .T_GAP(TG)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done), .rdata(rdata),
    .busy(busy), .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  rtc_bus_arbiter #(.T_PULSE(1), .T_GAP(1)) dut_b (
    .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_done(b_req_done), .rdata(b_rdata),
    .busy(b_busy), .cs_n(b_cs_n), .ad_n(b_ad_n), .rd_n(b_rd_n), .wr_n(b_wr_n),
    .ad_out(b_ad_out), .ad_oe(b_ad_oe), .ad_in(b_ad_in)
  );

  typedef struct {
    int         tag;
    int         len;
    logic [3:0] strb;   // {cs_n, ad_n, rd_n, wr_n}
    logic       oe;
    logic [7:0] out;
    logic [2:0] done;
    logic       bsy;
    logic [7:0] rd;
  } seg_t;

  seg_t segs[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [24:0] RESET_VEC = {4'b1111, 1'b0, 8'hFF, 3'b000, 1'b0, 8'h00};

  function automatic logic [24:0] obs(input bit b);
    if (b) return {b_cs_n, b_ad_n, b_rd_n, b_wr_n, b_ad_oe, b_ad_out, b_req_done, b_busy, b_rdata};
    return {cs_n, ad_n, rd_n, wr_n, ad_oe, ad_out, req_done, busy, rdata};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one request on the chosen instance and walk the pin table for that tag.
  task automatic run_seq(input int tag, input bit b, input int port, input bit wr,
                         input logic [7:0] addr, input logic [7:0] wdata);
    bit first = 1'b1;
    @(negedge clock);
    if (b) begin
      b_req_write[port] = wr; b_req_addr[port*8 +: 8] = addr;
      b_req_wdata[port*8 +: 8] = wdata; b_req_valid = 3'b001 << port;
    end else begin
      req_write[port] = wr; req_addr[port*8 +: 8] = addr;
      req_wdata[port*8 +: 8] = wdata; req_valid = 3'b001 << port;
    end
    @(posedge clock);
    foreach (segs[i]) begin
      if (segs[i].tag == tag) begin
        for (int c = 0; c < segs[i].len; c++) begin
          @(negedge clock);
          check($sformatf("seq%0d_row%0d_cyc%0d", tag, i, c), 32'(obs(b)),
                32'({segs[i].strb, segs[i].oe, segs[i].out, segs[i].done, segs[i].bsy, segs[i].rd}));
          if (first) begin
            // Latched fields must not follow the inputs after the grant.
            if (b) begin b_req_addr = ~b_req_addr; b_req_wdata = ~b_req_wdata; b_req_write = ~b_req_write; end
            else   begin req_addr = ~req_addr; req_wdata = ~req_wdata; req_write = ~req_write; end
            first = 1'b0;
          end
          if (segs[i].done != 3'b000) begin
            if (b) b_req_valid = '0; else req_valid = '0;
          end
        end
      end
    end
  endtask

  initial begin
    int cyc;

    // Write on port 0, defaults: addr 02, wdata 10.
    segs.push_back('{0, 1, 4'b1011, 1'b1, 8'h02, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 1, 4'b0011, 1'b1, 8'h02, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 5, 4'b0010, 1'b1, 8'h02, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 1, 4'b1111, 1'b1, 8'h02, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 8, 4'b1111, 1'b1, 8'h10, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 1, 4'b0111, 1'b1, 8'h10, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 5, 4'b0110, 1'b1, 8'h10, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 1, 4'b1111, 1'b0, 8'hFF, 3'b000, 1'b1, 8'h00});
    segs.push_back('{0, 1, 4'b1111, 1'b0, 8'hFF, 3'b001, 1'b1, 8'h00});
    segs.push_back('{0, 1, 4'b1111, 1'b0, 8'hFF, 3'b000, 1'b0, 8'h00});
    // Read on port 2, addr 21, ad_in 37.
    segs.push_back('{1, 1, 4'b1011, 1'b1, 8'h21, 3'b000, 1'b1, 8'h00});
    segs.push_back('{1, 1, 4'b0011, 1'b1, 8'h21, 3'b000, 1'b1, 8'h00});
    segs.push_back('{1, 5, 4'b0010, 1'b1, 8'h21, 3'b000, 1'b1, 8'h00});
    segs.push_back('{1, 1, 4'b1111, 1'b1, 8'h21, 3'b000, 1'b1, 8'h00});
    segs.push_back('{1, 8, 4'b1111, 1'b0, 8'hFF, 3'b000, 1'b1, 8'h00});
    segs.push_back('{1, 1, 4'b0111, 1'b0, 8'hFF, 3'b000, 1'b1, 8'h00});
    segs.push_back('{1, 5, 4'b0101, 1'b0, 8'hFF, 3'b000, 1'b1, 8'h00});
    segs.push_back('{1, 1, 4'b1111, 1'b0, 8'hFF, 3'b000, 1'b1, 8'h37});
    segs.push_back('{1, 1, 4'b1111, 1'b0, 8'hFF, 3'b100, 1'b1, 8'h37});
    segs.push_back('{1, 1, 4'b1111, 1'b0, 8'hFF, 3'b000, 1'b0, 8'h37});
    // Write on port 0 with T_PULSE=1, T_GAP=1: addr 5A, wdata A5, done 8 cycles in.
    segs.push_back('{2, 1, 4'b1011, 1'b1, 8'h5A, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b0011, 1'b1, 8'h5A, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b0010, 1'b1, 8'h5A, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b1111, 1'b1, 8'h5A, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b1111, 1'b1, 8'hA5, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b0111, 1'b1, 8'hA5, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b0110, 1'b1, 8'hA5, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b1111, 1'b0, 8'hFF, 3'b000, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b1111, 1'b0, 8'hFF, 3'b001, 1'b1, 8'h00});
    segs.push_back('{2, 1, 4'b1111, 1'b0, 8'hFF, 3'b000, 1'b0, 8'h00});

    reset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; ad_in = 8'h37;
    b_req_valid = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0; b_ad_in = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", 32'(obs(1'b0)), 32'(RESET_VEC));
    check("reset_state_b", 32'(obs(1'b1)), 32'(RESET_VEC));
    reset = 1'b1;

    run_seq(0, 1'b0, 0, 1'b1, 8'h02, 8'h10);
    run_seq(1, 1'b0, 2, 1'b0, 8'h21, 8'h00);
    ad_in = 8'h55;
    repeat (3) @(negedge clock);
    check("rdata_hold", 32'(rdata), 32'h37);
    run_seq(2, 1'b1, 0, 1'b1, 8'h5A, 8'hA5);

    // Port 1 withdraws its request two cycles after the grant.
    @(negedge clock);
    req_write = 3'b010; req_addr[15:8] = 8'h44; req_wdata[15:8] = 8'h66; req_valid = 3'b010;
    @(posedge clock);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clock);
      if (req_done != 3'b000) break;
      if (cyc == 2) req_valid = 3'b000;
      cyc++;
    end
    check("withdraw_done", 32'(req_done), 32'b010);
    check("withdraw_latency", 32'(cyc), 32'(2*TP + TG + 5));

    // Reset during GAP of a port-1 access, then all three requesters contend.
    @(negedge clock);
    req_valid = 3'b010;
    @(posedge clock);
    repeat (12) @(negedge clock);
    check("in_gap_busy", 32'({busy, ad_n, cs_n}), 32'b111);
    reset = 1'b0;
    req_valid = 3'b111; req_write = 3'b111; req_addr = 24'h332211; req_wdata = 24'hCCBBAA;
    @(negedge clock);
    check("reset_mid_access", 32'(obs(1'b0)), 32'({4'b1111, 1'b0, 8'hFF, 3'b000, 1'b0, 8'h00}));
    reset = 1'b1;

    for (int n = 0; n < 6; n++) begin
      cyc = (n == 0) ? 0 : 1;
      while (cyc < 100) begin
        @(negedge clock);
        if (req_done != 3'b000) break;
        cyc++;
      end
      check($sformatf("contend_order%0d", n), 32'(req_done), 32'(3'b001 << (n % 3)));
      check($sformatf("contend_latency%0d", n), 32'(cyc), 32'(2*TP + TG + 5));
      @(negedge clock);
      check($sformatf("contend_idle%0d", n), 32'({req_done, busy}), 32'b0000);
      @(negedge clock);
      check($sformatf("contend_regrant%0d", n), 32'({req_done, busy}), 32'b0001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
